// File: rtl/sram_emu_pkg.sv
// Shared types and constants for the on-chip SRAM responder.
package sram_emu_pkg;

  // Responder FSM: idle bus, write in progress, read in progress.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Default geometry matches the 32K x 8 board SRAM.
  localparam int AW_DEFAULT = 15;
  localparam int DW_DEFAULT = 8;
  localparam int CW_DEFAULT = 16;

  // Read latency bounds; the latency counter is LAT_W bits wide.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int LAT_W      = 3;

endpackage

// File: rtl/sram_emu_mem.sv
// Single-port synchronous RAM with registered read, written so that tools
// map it onto block RAM. Contents are never cleared by reset.
module sram_emu_mem #(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write-then-registered-read on the single shared address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_emu.sv
// Clocked responder for the asynchronous SRAM pins driven by sram_ctrl, used
// as an on-chip loopback. Pins are registered once, an FSM tracks write/read
// cycles, and counters plus a sticky error flag expose activity.
module sram_emu
  import sram_emu_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int DW     = DW_DEFAULT,
  parameter int RD_LAT = 2,
  parameter int CW     = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sram_cs_n,
  input  logic          sram_we_n,
  input  logic          sram_oe_n,
  input  logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] rd_cnt,
  output logic          proto_err
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_range
    $error("sram_emu: RD_LAT out of range 1..7");
  end

  // Registered copies of the pins; the FSM only ever looks at these.
  logic          cs_n_reg, we_n_reg, oe_n_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] din_reg;

  state_t        state_reg, state_next;

  logic [AW-1:0] ref_addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [AW-1:0] rd_addr_reg;
  logic [LAT_W-1:0] lat_cnt_reg;

  logic          write_entry, write_stay, commit;
  logic          read_entry, read_exit, addr_moved;
  logic          data_valid, drive_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  // Input register stage; strobes reset to their inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_reg <= 1'b1;
      we_n_reg <= 1'b1;
      oe_n_reg <= 1'b1;
      addr_reg <= '0;
      din_reg  <= '0;
    end else begin
      cs_n_reg <= sram_cs_n;
      we_n_reg <= sram_we_n;
      oe_n_reg <= sram_oe_n;
      addr_reg <= sram_addr;
      din_reg  <= sram_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a low we always wins over oe.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!cs_n_reg && !we_n_reg) begin
          state_next = WRITE;
        end else if (!cs_n_reg && !oe_n_reg) begin
          state_next = READ;
        end
      end
      WRITE: begin
        if (cs_n_reg || we_n_reg) begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (cs_n_reg) begin
          state_next = IDLE;
        end else if (!we_n_reg) begin
          state_next = WRITE;
        end else if (oe_n_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign write_entry = (state_next == WRITE) && (state_reg != WRITE);
  assign write_stay  = (state_reg == WRITE) && (state_next == WRITE);
  assign commit      = (state_reg == WRITE) && (state_next != WRITE);
  assign read_entry  = (state_next == READ) && (state_reg != READ);
  assign read_exit   = (state_reg == READ) && (state_next != READ);
  assign addr_moved  = (addr_reg != rd_addr_reg);

  // Valid only once the latency has elapsed for the address now presented.
  assign data_valid = (state_reg == READ) && (lat_cnt_reg == '0) && !addr_moved;
  // Drop the driver the same cycle the registered strobes release the bus.
  assign drive_en   = data_valid && !cs_n_reg && !oe_n_reg && we_n_reg;

  assign sram_data = drive_en ? mem_rdata : {DW{1'bz}};

  // Write reference pair: address fixed at entry, data refreshed while in WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_addr_reg <= '0;
      wdata_reg    <= '0;
    end else if (write_entry) begin
      ref_addr_reg <= addr_reg;
      wdata_reg    <= din_reg;
    end else if (write_stay) begin
      wdata_reg    <= din_reg;
    end
  end

  // Read latency counter. The load cycle itself counts as the first of the
  // RD_LAT cycles, so it loads RD_LAT-1 and data becomes valid at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_reg <= '0;
      rd_addr_reg <= '0;
    end else if (read_entry || ((state_reg == READ) && addr_moved)) begin
      lat_cnt_reg <= LAT_W'(RD_LAT - 1);
      rd_addr_reg <= addr_reg;
    end else if ((state_reg == READ) && (lat_cnt_reg != '0)) begin
      lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
    end
  end

  // Activity counters and sticky address-moved-during-write flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (commit) begin
        wr_cnt <= wr_cnt + CW'(1);
      end
      if (read_exit && data_valid) begin
        rd_cnt <= rd_cnt + CW'(1);
      end
      if (write_stay && (addr_reg != ref_addr_reg)) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Commit uses the reference address; otherwise the read port follows the bus.
  assign mem_we   = commit && !rst;
  assign mem_addr = commit ? ref_addr_reg : addr_reg;

  sram_emu_mem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(wdata_reg),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_sram_emu.sv
// Directed bench for sram_emu: write/read timing, address changes, write
// priority, protocol error and reset behaviour.
module tb_sram_emu;

  localparam int AW     = 15;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;
  localparam int CW     = 16;

  logic          clk;
  logic          rst;
  logic          cs_n, we_n, oe_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] tb_data;
  logic          tb_drv_en;
  wire  [DW-1:0] sram_data;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          proto_err;

  int n_assert = 0;
  int n_fail   = 0;

  assign sram_data = tb_drv_en ? tb_data : {DW{1'bz}};

  sram_emu #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CW(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sram_cs_n(cs_n),
    .sram_we_n(we_n),
    .sram_oe_n(oe_n),
    .sram_addr(addr),
    .sram_data(sram_data),
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    cs_n = 1'b0; we_n = 1'b0; addr = a; tb_data = d; tb_drv_en = 1'b1;
    tick(hold);
    cs_n = 1'b1; we_n = 1'b1; tb_drv_en = 1'b0;
    tick(3);
    $display("write addr=0x%04h data=0x%02h", a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    cs_n = 1'b0; oe_n = 1'b0; addr = a;
    tick(RD_LAT + 1);
    check(tag, {23'd0, dut.drive_en, sram_data}, {23'd0, 1'b1, exp});
    $display("read  addr=0x%04h data=0x%02h exp=0x%02h", a, sram_data, exp);
    cs_n = 1'b1; oe_n = 1'b1;
    tick(2);
  endtask

  // Bus contention: the emulator must never drive while the bench does.
  always @(negedge clk) begin
    if (tb_drv_en) begin
      check("contention", {31'd0, dut.drive_en}, 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; cs_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    addr = '0; tb_data = '0; tb_drv_en = 1'b0;
    tick(2);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst_proto", {31'd0, proto_err}, 32'd0);
    check("rst_hiz", {31'd0, dut.drive_en}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Write 0x5A @ 0x0123, we held 3 cycles; wr_cnt lags the registered we.
    cs_n = 1'b0; we_n = 1'b0; addr = 15'h0123; tb_data = 8'h5A; tb_drv_en = 1'b1;
    tick(3);
    cs_n = 1'b1; we_n = 1'b1; tb_drv_en = 1'b0;
    tick(1);
    check("wr_cnt_early", 32'(wr_cnt), 32'd0);
    tick(1);
    check("wr_cnt_commit", 32'(wr_cnt), 32'd1);
    $display("write addr=0x0123 data=0x5a wr_cnt=%0d", wr_cnt);
    tick(1);

    // Read it back: bus high-Z for two cycles, driven on the third.
    cs_n = 1'b0; oe_n = 1'b0; addr = 15'h0123;
    tick(1);
    check("rd_lat_c1", {31'd0, dut.drive_en}, 32'd0);
    tick(1);
    check("rd_lat_c2", {31'd0, dut.drive_en}, 32'd0);
    tick(1);
    check("rd_lat_c3", {23'd0, dut.drive_en, sram_data}, {23'd0, 1'b1, 8'h5A});
    cs_n = 1'b1; oe_n = 1'b1;
    tick(1);
    check("rd_release", {31'd0, dut.drive_en}, 32'd0);
    tick(1);
    check("rd_cnt_1", 32'(rd_cnt), 32'd1);
    $display("read  addr=0x0123 rd_cnt=%0d", rd_cnt);

    // Address change mid-read.
    wr(15'h0001, 8'h11, 2);
    wr(15'h0002, 8'h22, 2);
    cs_n = 1'b0; oe_n = 1'b0; addr = 15'h0001;
    tick(3);
    check("mv_first", {23'd0, dut.drive_en, sram_data}, {23'd0, 1'b1, 8'h11});
    addr = 15'h0002;
    tick(1);
    check("mv_hiz1", {31'd0, dut.drive_en}, 32'd0);
    tick(1);
    check("mv_hiz2", {31'd0, dut.drive_en}, 32'd0);
    tick(1);
    check("mv_second", {23'd0, dut.drive_en, sram_data}, {23'd0, 1'b1, 8'h22});
    cs_n = 1'b1; oe_n = 1'b1;
    tick(2);
    check("mv_rd_cnt", 32'(rd_cnt), 32'd2);
    $display("read  addr 0x0001->0x0002 rd_cnt=%0d", rd_cnt);

    // we and oe both low: write wins, emulator stays off the bus.
    cs_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 15'h0040; tb_data = 8'hA5; tb_drv_en = 1'b1;
    tick(3);
    cs_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_drv_en = 1'b0;
    tick(3);
    check("both_wr_cnt", 32'(wr_cnt), 32'd4);
    $display("write addr=0x0040 data=0xa5 with oe low wr_cnt=%0d", wr_cnt);
    rd(15'h0040, 8'hA5, "both_data");

    // Address change mid-write.
    check("proto_pre", {31'd0, proto_err}, 32'd0);
    wr(15'h0010, 8'h44, 2);
    wr(15'h0011, 8'h33, 2);
    cs_n = 1'b0; we_n = 1'b0; addr = 15'h0010; tb_data = 8'h77; tb_drv_en = 1'b1;
    tick(2);
    addr = 15'h0011;
    tick(1);
    cs_n = 1'b1; we_n = 1'b1; tb_drv_en = 1'b0;
    tick(1);
    check("proto_set", {31'd0, proto_err}, 32'd1);
    tick(2);
    check("proto_sticky", {31'd0, proto_err}, 32'd1);
    $display("write addr 0x0010->0x0011 proto_err=%0d", proto_err);
    rd(15'h0010, 8'h77, "proto_ref_addr");
    rd(15'h0011, 8'h33, "proto_other_addr");
    check("proto_still", {31'd0, proto_err}, 32'd1);

    // Reset mid-write: pending data 0x99 must be discarded.
    wr(15'h0020, 8'h55, 2);
    cs_n = 1'b0; we_n = 1'b0; addr = 15'h0020; tb_data = 8'h99; tb_drv_en = 1'b1;
    tick(3);
    rst = 1'b1;
    cs_n = 1'b1; we_n = 1'b1; tb_drv_en = 1'b0;
    tick(1);
    check("rstw_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rstw_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rstw_proto", {31'd0, proto_err}, 32'd0);
    check("rstw_hiz", {31'd0, dut.drive_en}, 32'd0);
    rst = 1'b0;
    tick(2);
    $display("reset mid-write addr=0x0020");
    rd(15'h0020, 8'h55, "rstw_unchanged");
    check("rstw_no_commit", 32'(wr_cnt), 32'd0);

    // Reset mid-read with the strobes still asserted.
    cs_n = 1'b0; oe_n = 1'b0; addr = 15'h0020;
    tick(3);
    check("rstr_driving", {23'd0, dut.drive_en, sram_data}, {23'd0, 1'b1, 8'h55});
    rst = 1'b1;
    tick(1);
    check("rstr_hiz", {31'd0, dut.drive_en}, 32'd0);
    check("rstr_rd_cnt", 32'(rd_cnt), 32'd0);
    rst = 1'b0;
    cs_n = 1'b1; oe_n = 1'b1;
    tick(3);
    check("rstr_rd_cnt_after", 32'(rd_cnt), 32'd0);
    $display("reset mid-read addr=0x0020 rd_cnt=%0d", rd_cnt);

    // Sequential fill of 0x7F00..0x7FFF and read-back from clean counters.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 256; i++) begin
      wr(AW'(32'h7F00 + i), DW'(i), 1);
    end
    for (int i = 0; i < 256; i++) begin
      rd(AW'(32'h7F00 + i), DW'(i), "seq_data");
    end
    check("seq_wr_cnt", 32'(wr_cnt), 32'd256);
    check("seq_rd_cnt", 32'(rd_cnt), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
